// File: rtl/jt51_mixacc.sv
// jt51_mixacc: sums carrier operators per channel and mixes the eight channels
// into saturated 16-bit left/right samples, one sample strobe per 32-slot frame.
module jt51_mixacc (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               zero,
    input  logic signed [13:0] op_XVII,
    input  logic        [2:0]  con,
    input  logic        [1:0]  rl,
    output logic signed [15:0] left,
    output logic signed [15:0] right,
    output logic               sample
);
    logic        [4:0]  r_slot;
    logic signed [15:0] r_chacc [0:7];
    logic signed [18:0] r_mixl;
    logic signed [18:0] r_mixr;
    logic               r_trunc;

    logic        [4:0]  w_slot;
    logic        [2:0]  w_ch;
    logic        [1:0]  w_group;
    logic               w_carrier;
    logic               w_resync;
    logic signed [15:0] w_term;
    logic signed [15:0] w_chtot;
    logic signed [18:0] w_gl;
    logic signed [18:0] w_gr;
    logic signed [18:0] w_suml;
    logic signed [18:0] w_sumr;

    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return 16'sh7fff;
        else if (v < -19'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // A zero marker forces the current cycle to be slot 0 regardless of the counter.
    assign w_slot   = zero ? 5'd0 : r_slot;
    assign w_ch     = w_slot[2:0];
    assign w_group  = w_slot[4:3];
    assign w_resync = zero && (r_slot != 5'd0);

    always_comb begin
        w_carrier = 1'b1;
        case (w_group)
            2'd0:    w_carrier = (con == 3'd7);
            2'd1:    w_carrier = (con >= 3'd5);
            2'd2:    w_carrier = (con >= 3'd4);
            default: w_carrier = 1'b1;
        endcase
    end

    assign w_term  = w_carrier ? {{2{op_XVII[13]}}, op_XVII} : 16'sd0;
    assign w_chtot = r_chacc[w_ch] + w_term;
    assign w_gl    = rl[0] ? {{3{w_chtot[15]}}, w_chtot} : 19'sd0;
    assign w_gr    = rl[1] ? {{3{w_chtot[15]}}, w_chtot} : 19'sd0;
    assign w_suml  = r_mixl + w_gl;
    assign w_sumr  = r_mixr + w_gr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= 5'd0;
            for (int i = 0; i < 8; i++)
                r_chacc[i] <= 16'sd0;
            r_mixl  <= 19'sd0;
            r_mixr  <= 19'sd0;
            r_trunc <= 1'b0;
            left    <= 16'sd0;
            right   <= 16'sd0;
            sample  <= 1'b0;
        end else if (cen) begin
            r_slot <= w_slot + 5'd1;

            case (w_group)
                2'd0:       r_chacc[w_ch] <= w_term;
                2'd1, 2'd2: r_chacc[w_ch] <= r_chacc[w_ch] + w_term;
                default:    r_chacc[w_ch] <= r_chacc[w_ch];
            endcase

            // C2 slots 24..31 carry each channel's final total into the mix.
            if (w_slot == 5'd24) begin
                r_mixl <= w_gl;
                r_mixr <= w_gr;
            end else if (w_slot > 5'd24) begin
                r_mixl <= w_suml;
                r_mixr <= w_sumr;
            end

            sample <= 1'b0;
            if (w_slot == 5'd31) begin
                r_trunc <= 1'b0;
                if (!r_trunc) begin
                    left   <= sat16(w_suml);
                    right  <= sat16(w_sumr);
                    sample <= 1'b1;
                end
            end else if (w_resync) begin
                r_trunc <= 1'b1;
            end
        end
    end
endmodule

// File: doc/jt51_mixacc.md
# jt51_mixacc

Per-frame output accumulator on the consumer side of the operator pipeline's sample output. It receives one signed 14-bit operator sample per slot, selects carrier operators from each channel's connection algorithm, and sums them per channel. It then mixes the eight channels into saturated 16-bit left and right samples with a one-cen-period sample strobe per 32-slot frame. It sits between the operator pipeline and the DAC/output formatter.

## Interface
Parameters:
- none (frame length 32 slots, 8 channels, fixed)

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  clock enable; all state advances only on clk edges with cen=1
- zero  in  1  frame marker; high during the cen cycle that carries slot 0
- op_XVII  in  14 signed  operator output sample for the current slot
- con  in  3  connection algorithm of the current slot's channel, aligned with op_XVII
- rl  in  2  output enables of the current slot's channel: rl[1]=right, rl[0]=left, aligned with op_XVII
- left  out  16 signed  left sample of the last completed frame
- right  out  16 signed  right sample of the last completed frame
- sample  out  1  high for exactly one cen period when left/right update

## Operation
- slot: 5-bit counter, increments on each cen edge, wraps 31->0. Each edge with zero=1 loads slot=1, meaning the current cycle is slot 0.
- Slot decode: ch = slot[2:0]; group = slot[4:3]; 0=M1, 1=M2, 2=C1, 3=C2.
- Carrier select: C2 is always a carrier. C1 is a carrier for con>=4. M2 is a carrier for con>=5. M1 is a carrier for con=7.
- term = carrier ? sign-extended op_XVII : 0.
- Channel accumulators chacc[0..7], 16-bit signed. A channel sum cannot exceed 4x8191, so no saturation is needed here.
  - M1 slot: chacc[ch] <= term (overwrite, starts the channel).
  - M2 and C1 slots: chacc[ch] <= chacc[ch] + term.
  - C2 slot: chtot = chacc[ch] + term (combinational).
- Mix accumulators mixl and mixr, 19-bit signed.
  - Slot 24: mixl <= rl[0] ? chtot : 0; mixr <= rl[1] ? chtot : 0.
  - Slots 25-30: mixl and mixr add chtot if the corresponding rl bit is set.
  - Slot 31: left <= sat16(mixl + gated chtot); right likewise; sample <= 1.
- Any other cen edge sets sample <= 0.
- sat16 clamps to [-32768, 32767].
- Resync: zero=1 arriving when the internal slot is not 0 marks the frame as truncated. The next slot-31 edge still updates chacc but leaves left/right unchanged and keeps sample=0. The flag clears at that slot 31. From then on, operation is normal.
- Reset: slot=0, all chacc=0, mixl=mixr=0, left=0, right=0, sample=0, truncated flag=0.
- Reset asserted mid-frame aborts the frame. No sample pulse occurs until a full frame completes after reset.
- The counter runs from reset without a zero. The first frame after reset is valid only if the counter and zero agree.

## Timing
- Each input sample is consumed on the cen edge of its own slot, with zero pipeline latency to chacc.
- left, right and sample update on the slot-31 cen edge. The outputs are registered and valid from that edge until the next slot-31 edge.
- sample stays high across cen=0 cycles until the next cen edge. It is high for exactly one cen period.
- cen=0: all registers hold, including sample.
- Frame period is 32 cen cycles. Outputs update once per frame.
- zero and rst on the same edge: rst wins.

## Test plan
- Alg 7, channel 0: all four operators = 100, rl=11, other channels 0. Expect left=right=400 and one sample pulse after slot 31.
- Alg 0, channel 0: M1=M2=C1=1000, C2=-50, rl=11. Expect left=right=-50, with the modulators excluded.
- Alg 4, channel 3: C1=200, C2=300, M1=M2=777, rl=01. Expect left=500, right=0.
- Saturation: alg 7, all channels, all ops 8191, rl=11. Expect left=right=32767. Then all ops -8192. Expect -32768.
- Resync: zero at internal slot 12. Expect no sample pulse for that frame and left/right unchanged. The following frame with alg 7, ch0 ops=10 gives left=right=40.
- cen toggling 1/0 with the scenario 1 stimulus: results identical, and sample lasts 2 clk. Then rst mid-frame: left=right=0, sample=0 until the next complete frame.
